// File: rtl/serial_eq_checker.sv
// Bit-serial equality compare of two LSB-first operands with x/z tracking and width extension.
// done pulses one cycle after the last beat is accepted; bit_valid=0 stalls RUN, and beats outside RUN are dropped.
module serial_eq_checker #(
    parameter int MAXW = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] a_width,
    input  logic [5:0] b_width,
    input  logic       a_signed,
    input  logic       b_signed,
    input  logic       bit_valid,
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic       a_xz,
    input  logic       b_xz,
    output logic       busy,
    output logic       done,
    output logic       eq,
    output logic       unknown
);

    localparam logic [5:0] MAXW6 = 6'(MAXW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [5:0] a_w, b_w, len, cnt;
    logic [5:0] a_wc, b_wc;
    logic       sgn;
    logic       a_msb, a_msb_xz, b_msb, b_msb_xz;
    logic       mism, amb;

    logic       accept, take, last;
    logic       a_cur, a_cur_xz, b_cur, b_cur_xz;
    logic       beat_mism, beat_amb, mism_n, amb_n;

    function automatic logic [5:0] clamp_w(input logic [5:0] w);
        if (w == 6'd0)
            return 6'd1;
        else if (w > MAXW6)
            return MAXW6;
        else
            return w;
    endfunction

    assign a_wc   = clamp_w(a_width);
    assign b_wc   = clamp_w(b_width);
    assign accept = (state == IDLE) && start;
    assign take   = (state == RUN) && bit_valid;
    assign last   = (cnt == len - 6'd1);

    // Past an operand's own width the bit comes from its extension, not the inputs.
    always_comb begin
        a_cur    = 1'b0;
        a_cur_xz = 1'b0;
        b_cur    = 1'b0;
        b_cur_xz = 1'b0;
        if (cnt < a_w) begin
            a_cur    = a_bit;
            a_cur_xz = a_xz;
        end else begin
            a_cur    = sgn & a_msb;
            a_cur_xz = sgn & a_msb_xz;
        end
        if (cnt < b_w) begin
            b_cur    = b_bit;
            b_cur_xz = b_xz;
        end else begin
            b_cur    = sgn & b_msb;
            b_cur_xz = sgn & b_msb_xz;
        end
    end

    assign beat_mism = !a_cur_xz && !b_cur_xz && (a_cur != b_cur);
    assign beat_amb  = a_cur_xz || b_cur_xz;
    assign mism_n    = mism | beat_mism;
    assign amb_n     = amb | beat_amb;

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_n = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (bit_valid && last)
                    state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_w      <= 6'd0;
            b_w      <= 6'd0;
            len      <= 6'd0;
            cnt      <= 6'd0;
            sgn      <= 1'b0;
            a_msb    <= 1'b0;
            a_msb_xz <= 1'b0;
            b_msb    <= 1'b0;
            b_msb_xz <= 1'b0;
            mism     <= 1'b0;
            amb      <= 1'b0;
            eq       <= 1'b0;
            unknown  <= 1'b0;
        end else if (accept) begin
            a_w      <= a_wc;
            b_w      <= b_wc;
            len      <= (a_wc > b_wc) ? a_wc : b_wc;
            cnt      <= 6'd0;
            sgn      <= a_signed & b_signed;
            a_msb    <= 1'b0;
            a_msb_xz <= 1'b0;
            b_msb    <= 1'b0;
            b_msb_xz <= 1'b0;
            mism     <= 1'b0;
            amb      <= 1'b0;
            eq       <= 1'b0;
            unknown  <= 1'b0;
        end else if (take) begin
            cnt  <= cnt + 6'd1;
            mism <= mism_n;
            amb  <= amb_n;
            if (cnt == a_w - 6'd1) begin
                a_msb    <= a_bit;
                a_msb_xz <= a_xz;
            end
            if (cnt == b_w - 6'd1) begin
                b_msb    <= b_bit;
                b_msb_xz <= b_xz;
            end
            // A known mismatch outranks ambiguity.
            if (last) begin
                eq      <= !mism_n && !amb_n;
                unknown <= !mism_n && amb_n;
            end
        end
    end

endmodule

// File: tb/tb_serial_eq_checker.sv
// Scoreboarded random and directed bench for serial_eq_checker; the model works on whole operand vectors.
module tb_serial_eq_checker;

    localparam int MAXW = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] a_width = 6'd0;
    logic [5:0] b_width = 6'd0;
    logic       a_signed = 1'b0;
    logic       b_signed = 1'b0;
    logic       bit_valid = 1'b0;
    logic       a_bit = 1'b0;
    logic       b_bit = 1'b0;
    logic       a_xz = 1'b0;
    logic       b_xz = 1'b0;
    logic       busy, done, eq, unknown;

    serial_eq_checker #(.MAXW(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_width(a_width), .b_width(b_width),
        .a_signed(a_signed), .b_signed(b_signed),
        .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit),
        .a_xz(a_xz), .b_xz(b_xz),
        .busy(busy), .done(done), .eq(eq), .unknown(unknown)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic eq;
        logic unk;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("eq", {63'd0, eq}, {63'd0, e.eq});
                chk("unknown", {63'd0, unknown}, {63'd0, e.unk});
            end
        end
    end

    function automatic int clampw(input int w);
        if (w == 0) return 1;
        if (w > MAXW) return MAXW;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_bits();
        a_bit = 1'($urandom_range(0, 1));
        b_bit = 1'($urandom_range(0, 1));
        a_xz  = 1'($urandom_range(0, 1));
        b_xz  = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_start(input int aw, input int bw, input logic as, input logic bs);
        start     = 1'b1;
        a_width   = 6'(aw);
        b_width   = 6'(bw);
        a_signed  = as;
        b_signed  = bs;
        bit_valid = 1'($urandom_range(0, 1));
        junk_bits();
        tick();
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("eq_cleared", {62'd0, eq, unknown}, 64'd0);
    endtask

    task automatic run_cmp(input int aw, input int bw, input logic as, input logic bs,
                           input logic [63:0] av_in, input logic [63:0] axm_in,
                           input logic [63:0] bv_in, input logic [63:0] bxm_in,
                           input int maxgap);
        int awc, bwc, len;
        logic sgn;
        logic [63:0] av, axm, bv, bxm, lmask;
        exp_t e;
        awc = clampw(aw);
        bwc = clampw(bw);
        len = (awc > bwc) ? awc : bwc;
        sgn = as && bs;
        av = av_in; axm = axm_in; bv = bv_in; bxm = bxm_in;
        for (int i = awc; i < 64; i++) begin
            av[i]  = sgn ? av[awc-1]  : 1'b0;
            axm[i] = sgn ? axm[awc-1] : 1'b0;
        end
        for (int i = bwc; i < 64; i++) begin
            bv[i]  = sgn ? bv[bwc-1]  : 1'b0;
            bxm[i] = sgn ? bxm[bwc-1] : 1'b0;
        end
        lmask = (64'd1 << len) - 64'd1;
        e.eq  = ((((av ^ bv) & ~axm & ~bxm) | axm | bxm) & lmask) == 64'd0;
        e.unk = ((((av ^ bv) & ~axm & ~bxm) & lmask) == 64'd0) && (((axm | bxm) & lmask) != 64'd0);
        e.cyc = 0;

        drive_start(aw, bw, as, bs);
        for (int k = 0; k < len; k++) begin
            int gap;
            gap = $urandom_range(0, maxgap);
            for (int g = 0; g < gap; g++) begin
                bit_valid = 1'b0;
                junk_bits();
                tick();
            end
            bit_valid = 1'b1;
            junk_bits();
            if (k < awc) begin a_bit = av_in[k]; a_xz = axm_in[k]; end
            if (k < bwc) begin b_bit = bv_in[k]; b_xz = bxm_in[k]; end
            if (k == len - 1) begin
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
            tick();
        end
        for (int j = 0; j < 2; j++) begin
            bit_valid = 1'($urandom_range(0, 1));
            junk_bits();
            tick();
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_eq_unknown", {62'd0, eq, unknown}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_cmp(1, 2, 1'b1, 1'b0, 64'h1, 64'h0, 64'h3, 64'h0, 1);
        run_cmp(1, 2, 1'b1, 1'b1, 64'h1, 64'h0, 64'h3, 64'h0, 1);
        run_cmp(32, 32, 1'b0, 1'b0, 64'd10, 64'h0, 64'd10, 64'h0, 3);
        run_cmp(32, 32, 1'b0, 1'b0, 64'h0, 64'hFFFF_FFFF, 64'd20, 64'h0, 0);
        run_cmp(4, 4, 1'b0, 1'b0, 64'h8, 64'h4, 64'h0, 64'h4, 1);

        // Abort mid-run: reset lands while beat 5 is on the inputs.
        drive_start(16, 16, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            bit_valid = 1'b1;
            junk_bits();
            tick();
        end
        bit_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_eq_unknown", {62'd0, eq, unknown}, 64'd0);
        bit_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        run_cmp(8, 8, 1'b0, 1'b0, 64'd3, 64'h0, 64'd3, 64'h0, 2);

        for (int t = 0; t < 40; t++) begin
            logic [63:0] av, axm, bv, bxm;
            av  = {$urandom, $urandom};
            axm = ($urandom_range(0, 1) == 1) ? 64'h0 :
                  ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            bv  = ($urandom_range(0, 1) == 1) ? av : {$urandom, $urandom};
            bxm = ($urandom_range(0, 2) == 0) ? axm : 64'h0;
            run_cmp($urandom_range(0, 63), $urandom_range(0, 63),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    av, axm, bv, bxm, 2);
        end

        for (int w = 0; w < 10 && exp_q.size() != 0; w++)
            tick();
        chk("pending_results", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_eq_checker.md
SERIAL_EQ_CHECKER -- requirements
Module: serial_eq_checker

Interface
REQ-001 Parameter MAXW, default 32: maximum operand width in bits (1..63).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  begins a comparison when the block is idle.
REQ-005 a_width, b_width  input  6 each  operand widths, sampled on accepted start.
REQ-006 a_signed, b_signed  input  1 each  operand signedness, sampled on accepted start.
REQ-007 bit_valid  input  1  one operand bit pair is presented this cycle.
REQ-008 a_bit, b_bit  input  1 each  operand bit values, streamed LSB first.
REQ-009 a_xz, b_xz  input  1 each  marks the corresponding bit as x/z; the bit value is ignored when set.
REQ-010 busy  output  1  a comparison is in progress.
REQ-011 done  output  1  one-cycle pulse indicating the result is valid.
REQ-012 eq  output  1  definite equality result.
REQ-013 unknown  output  1  ambiguous result, equivalent to 'bx.

Function
REQ-014 Width handling:
- A sampled width of 0 is treated as 1.
- A sampled width above MAXW is clamped to MAXW.
- Comparison length is L = max(a_width, b_width).
REQ-015 Extension rule:
- Signed extension applies only when a_signed and b_signed are both 1.
- Otherwise both operands are zero-extended to L.
REQ-016 Beat handling: the block accepts exactly L beats, one per cycle with bit_valid=1; cycles with bit_valid=0 stall without changing state.
REQ-017 Beat k (0-based) for operand A:
- k < a_width: use a_bit/a_xz.
- k >= a_width: the inputs are ignored and the extension bit is used.
- The extension bit is the latched MSB (including its x/z flag) under signed extension, and known 0 otherwise.
- Operand B follows the same rule with b_width.
REQ-018 Per-beat tracking:
- Set the sticky flag mism when both bits are known and differ.
- Set the sticky flag amb when either bit is x/z.
REQ-019 Result priority:
- mism=1 gives eq=0, unknown=0.
- Else amb=1 gives eq=0, unknown=1.
- Else eq=1, unknown=0.
REQ-020 State machine: IDLE -> RUN on start; RUN -> DONE on acceptance of beat L-1; DONE -> IDLE unconditionally after one cycle.
REQ-021 busy=1 in RUN only; done=1 in DONE only.
REQ-022 Latency: done asserts on the clock cycle after the last beat is accepted.
REQ-023 eq and unknown update when DONE is entered and hold until the next accepted start, which clears both to 0.
REQ-024 In IDLE or DONE, bit_valid is ignored; beats presented in those cycles are not counted.
REQ-025 A start during RUN or DONE is ignored.
REQ-026 A start in IDLE with simultaneous bit_valid=1:
- The start is accepted.
- The beat in that same cycle is not consumed; beat 0 comes on a later cycle.
REQ-027 Beat counter:
- Width is 6 bits.
- The counter never wraps, because L <= MAXW < 64.
- A mism already set does not stop beat consumption; all L beats are still taken.

Reset
REQ-028 While rst=1, asynchronously:
- State = IDLE.
- busy=0, done=0, eq=0, unknown=0.
- mism=0, amb=0, beat counter=0.
REQ-029 A reset during RUN aborts the comparison: no done pulse is produced and partial flags are discarded.
REQ-030 After reset deasserts, the first rising edge with start=1 is accepted normally.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- a_width=1 signed 1, b_width=2 unsigned 11 -> zero extension, A=01 vs 11 -> eq=0, unknown=0.
- a_width=1 signed 1, b_width=2 signed 11 -> sign extension -> eq=1, unknown=0.
- 32-bit unsigned 10 vs 10, with bit_valid gaps of 0-3 cycles -> done exactly 1 cycle after beat 31; eq=1.
- A all-x (32 bits) vs 20 -> eq=0, unknown=1.
- A=4'b1x00 vs B=4'b0x00 -> known mismatch dominates -> eq=0, unknown=0.
- rst asserted at beat 5 of 16 -> all outputs 0 immediately and no done pulse; a following 8-bit 3 vs 3 comparison -> eq=1.
